// File: rtl/i2s_pkg.sv
// Shared I2S definitions: FSM encoding, channel codes and SCK divider derivation.
// Used by both the transmitter and the receiver.
package i2s_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  // System clocks per SCK half period, truncated.
  function automatic int unsigned calc_half(input int unsigned clk_freq,
                                            input int unsigned sck_freq);
    return clk_freq / (2 * sck_freq);
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S bit clock generator: divides clk down to SCK and strobes the clk cycle
// before each SCK edge. Held low and reset while not running.
module i2s_clk_gen #(
  parameter int unsigned HALF = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  output logic o_sck,
  output logic o_fall,
  output logic o_rise
);

  localparam int unsigned CntW = (HALF > 2) ? $clog2(HALF) : 1;

  if (HALF < 2) begin : g_bad_half
    $error("i2s_clk_gen: HALF must be at least 2");
  end

  logic [CntW-1:0] r_div_cnt;
  logic            r_sck;
  logic            w_wrap;

  assign w_wrap = i_run & (r_div_cnt == CntW'(HALF - 1));
  assign o_sck  = r_sck;
  assign o_fall = w_wrap & r_sck;
  assign o_rise = w_wrap & ~r_sck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_sck     <= 1'b0;
    end else if (!i_run) begin
      r_div_cnt <= '0;
      r_sck     <= 1'b0;
    end else if (w_wrap) begin
      r_div_cnt <= '0;
      r_sck     <= ~r_sck;
    end else begin
      r_div_cnt <= r_div_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/i2s_transmitter.sv
// I2S master transmitter: 1-deep sample holding register feeding an MSB-first
// serialiser, with frame-aligned start/stop and zero-fill on underrun.
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned I2S_CLK_FREQ = 3_072_000,
  parameter int unsigned DATA_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic [DATA_WIDTH-1:0] pcm_data_i,
  input  logic                  pcm_valid_i,
  output logic                  pcm_ready_o,
  output logic                  i2s_clk_o,
  output logic                  i2s_ws_o,
  output logic                  i2s_data_o,
  output logic                  underrun_o,
  output logic                  busy_o
);

  localparam int unsigned HALF = calc_half(CLK_FREQ, I2S_CLK_FREQ);
  localparam int unsigned BitW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  if (DATA_WIDTH < 2) begin : g_bad_width
    $error("i2s_transmitter: DATA_WIDTH must be at least 2");
  end

  logic [1:0]            r_state, w_state_d;
  logic [DATA_WIDTH-1:0] r_hold, r_shift, w_word;
  logic [BitW-1:0]       r_bit_cnt;
  logic                  r_hold_valid, r_ws, r_data, r_underrun, r_frame_end;
  logic                  w_run, w_sck, w_fall, w_rise, w_accept;
  logic                  w_slot, w_to_idle, w_load, w_bypass, w_last_bit;

  i2s_clk_gen #(
    .HALF(HALF)
  ) u_clk_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .i_run (w_run),
    .o_sck (w_sck),
    .o_fall(w_fall),
    .o_rise(w_rise)
  );

  assign w_run      = (r_state != ST_IDLE);
  assign w_accept   = pcm_valid_i & ~r_hold_valid;
  assign w_slot     = w_fall & (r_bit_cnt == '0);
  // The slot after the right LSB seen in STOP ends the stream instead of loading.
  assign w_to_idle  = w_slot & (r_state == ST_STOP) & r_frame_end;
  assign w_load     = w_slot & ~w_to_idle;
  assign w_bypass   = w_load & w_accept;
  assign w_word     = r_hold_valid ? r_hold : (w_accept ? pcm_data_i : '0);
  assign w_last_bit = w_fall & (r_bit_cnt == BitW'(DATA_WIDTH - 1));

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_IDLE: if (enable_i) w_state_d = ST_RUN;
      ST_RUN:  if (!enable_i) w_state_d = ST_STOP;
      ST_STOP: begin
        if (w_to_idle) w_state_d = ST_IDLE;
        else if (enable_i) w_state_d = ST_RUN;
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_ws         <= WS_LEFT;
      r_data       <= 1'b0;
      r_underrun   <= 1'b0;
      r_frame_end  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_underrun <= w_load & ~r_hold_valid & ~w_accept;

      if (w_load && r_hold_valid) begin
        r_hold_valid <= 1'b0;
      end else if (w_accept && !w_bypass) begin
        r_hold       <= pcm_data_i;
        r_hold_valid <= 1'b1;
      end

      if (w_to_idle) begin
        r_data      <= 1'b0;
        r_bit_cnt   <= '0;
        r_frame_end <= 1'b0;
      end else if (w_load) begin
        r_data      <= w_word[DATA_WIDTH-1];
        r_shift     <= {w_word[DATA_WIDTH-2:0], 1'b0};
        r_bit_cnt   <= BitW'(1);
        r_frame_end <= 1'b0;
      end else if (w_fall) begin
        r_data    <= r_shift[DATA_WIDTH-1];
        r_shift   <= {r_shift[DATA_WIDTH-2:0], 1'b0};
        r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + BitW'(1);
      end

      // WS leads the next word's MSB by one SCK.
      if (w_last_bit) begin
        r_ws <= ~r_ws;
        if (r_state == ST_STOP && r_ws == WS_RIGHT) r_frame_end <= 1'b1;
      end
    end
  end

  a_edge_exclusive : assert property (@(posedge clk) disable iff (!rst_n) !(w_rise && w_fall));

  assign pcm_ready_o = ~r_hold_valid;
  assign i2s_clk_o   = w_sck;
  assign i2s_ws_o    = r_ws;
  assign i2s_data_o  = r_data;
  assign underrun_o  = r_underrun;
  assign busy_o      = w_run;

endmodule
